instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscado_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscado_pkg.sv
// Shared fetch-path types and defaults used by instr_fetch and fetch_fifo.
package riscado_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_FIFO_DEPTH = 4;

  // One buffered instruction together with the byte address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush. A push is accepted while full
// when a pop happens in the same cycle. The head reads as zero when empty.
module fetch_fifo
  import riscado_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Pointers and occupancy; flush and reset both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents only matter between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to a one-cycle registered ROM,
// buffers the returned words with their PCs and hands them to a valid/ready
// consumer. Redirect flushes everything and restarts at a new address.
// Optional build macro IFETCH_PERF_CNT_EN adds fetchCount / stallCount.
module instr_fetch
  import riscado_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        romEnable,
  output logic [31:0] romAddress,
  input  logic [31:0] romData,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_entry_t    head, wentry;
  logic            empty, full, inflight, issue, push, pop;
  logic [CW-1:0]   count;
  logic [CW:0]     pending;
  logic [31:0]     fetchPc, inflightPc;

  // Buffered plus outstanding words must leave room for the new request,
  // so a returning word always finds a free slot.
  assign pending    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue      = !reset && !redirect && !full && (pending < (CW+1)'(FIFO_DEPTH));
  assign romEnable  = issue;
  assign romAddress = fetchPc;

  // romData is only meaningful the cycle after an issue; a redirect drops it.
  assign push       = inflight && !redirect;
  assign pop        = instrValid && instrReady && !redirect;
  assign wentry     = '{pc: inflightPc, instr: romData};

  assign instrValid = !empty && !reset;
  assign instr      = head.instr;
  assign instrPc    = head.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Fetch PC and the single outstanding-request tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc    <= align_pc(RESET_PC);
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else if (redirect) begin
      fetchPc    <= align_pc(redirectPc);
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetchPc    <= fetchPc + 32'd4;
        inflightPc <= fetchPc;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Event counters: ROM issues and consumer back-pressure cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (issue)                     fetchCount <= fetchCount + 32'd1;
      if (instrValid && !instrReady) stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. The reference model is the expected
// program-order PC stream: consecutive words from the last (re)start point,
// each carrying ROM word A000_0000 + pc/4.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect, instrReady;
  logic [31:0] redirectPc;
  logic        romEnable, instrValid;
  logic [31:0] romAddress, romData, instr, instrPc;

  int checks = 0, failures = 0;
  int issued = 0, consumed = 0;
  logic [31:0] exp_q [$];

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .romEnable  (romEnable),
    .romAddress (romAddress),
    .romData    (romData),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instr      (instr),
    .instrPc    (instrPc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Registered ROM; garbage when not enabled so stale pushes show up.
  always @(posedge clk) romData <= romEnable ? rom_word(romAddress) : $urandom();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream restarts at an aligned address; older entries die.
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back((pc & 32'hFFFF_FFFC) + 32'(4 * i));
  endtask

  task automatic monitor();
    logic        hold = 1'b0;
    logic [31:0] hi = '0, hp = '0, e;
    forever begin
      @(negedge clk);
      if (romEnable) issued++;
      if (reset || redirect) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(instrValid), 32'd1);
          chk("hold_instr", instr, hi);
          chk("hold_pc", instrPc, hp);
        end
        if (instrValid && instrReady) begin
          consumed++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual_pc=%h expected=none", instrPc);
          end else begin
            e = exp_q.pop_front();
            chk("instrPc", instrPc, e);
            chk("instr", instr, rom_word(e));
            exp_q.push_back(exp_q.size() == 0 ? e + 32'd4 : exp_q[$] + 32'd4);
          end
        end
        hold = instrValid && !instrReady;
        hi   = instr;
        hp   = instrPc;
      end
    end
  endtask

  initial begin
    logic [4:0]  vbits;
    logic [31:0] c_i, c_p;
    int          base_i, found;

    reset = 1'b1; redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
    fork monitor(); join_none

    repeat (3) tick();
    @(negedge clk);
    chk("rst_romEnable", 32'(romEnable), 32'd0);
    chk("rst_instrValid", 32'(instrValid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instrPc", instrPc, 32'd0);

    // Reset release, streaming with ready high.
    tick();
    reset = 1'b0; instrReady = 1'b1; sb_restart(RPC);
    vbits = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("first_romEnable", 32'(romEnable), 32'd1);
        chk("first_romAddress", romAddress, RPC);
      end
      vbits[k] = instrValid;
      tick();
    end
    chk("valid_pattern", 32'(vbits), 32'h1C);
    chk("consumed_3", consumed, 32'd3);

    // Back-pressure for 10 cycles.
    instrReady = 1'b0;
    @(negedge clk);
    c_i = instr; c_p = instrPc;
    chk("stall_head_pc", c_p, 32'h0000_000C);
    repeat (9) tick();
    @(negedge clk);
    chk("stall_romEnable", 32'(romEnable), 32'd0);
    chk("stall_valid", 32'(instrValid), 32'd1);
    chk("stall_instr", instr, c_i);
    chk("stall_pc", instrPc, c_p);
    chk("stall_buffered", issued - consumed, 32'd4);
    tick();
    instrReady = 1'b1;
    repeat (20) tick();

    // Redirect with 3 buffered and 1 in flight.
    reset = 1'b1; instrReady = 1'b0;
    tick(); tick();
    reset = 1'b0; sb_restart(RPC); base_i = issued; found = 0;
    #1;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (!romEnable) begin
        found = 1;
        chk("redir_outstanding", issued - base_i, 32'd4);
        redirect = 1'b1; redirectPc = 32'h0000_0102; sb_restart(32'h0000_0100);
      end else tick();
    end
    chk("redir_setup", 32'(found), 32'd1);
    tick();
    redirect = 1'b0; instrReady = 1'b1;
    #1;
    chk("redir_valid_low", 32'(instrValid), 32'd0);
    chk("redir_romEnable", 32'(romEnable), 32'd1);
    chk("redir_romAddress", romAddress, 32'h0000_0100);
    repeat (10) tick();

    // Back-to-back redirects: only the second counts.
    redirect = 1'b1; redirectPc = 32'h0000_0040;
    tick();
    redirectPc = 32'h0000_0080; sb_restart(32'h0000_0080);
    tick();
    redirect = 1'b0;
    #1;
    chk("b2b_romAddress", romAddress, 32'h0000_0080);
    chk("b2b_romEnable", 32'(romEnable), 32'd1);
    repeat (10) tick();

    // Address wrap at the top of the space.
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC; sb_restart(32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap_romAddress0", romAddress, 32'hFFFF_FFFC);
    tick();
    chk("wrap_romAddress1", romAddress, 32'h0000_0000);
    chk("wrap_romEnable", 32'(romEnable), 32'd1);
    repeat (10) tick();

    // One-cycle reset with a request in flight.
    chk("rst_inflight_setup", 32'(romEnable), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("rst1_romEnable", 32'(romEnable), 32'd0);
    chk("rst1_instrValid", 32'(instrValid), 32'd0);
    sb_restart(RPC);
    tick();
    reset = 1'b0;
    #1;
    chk("rst1_romAddress", romAddress, RPC);
    chk("rst1_restart", 32'(romEnable), 32'd1);
    repeat (10) tick();

    // Randomized traffic: ready jitter, redirects and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      int r;
      instrReady = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset = 1'b0; redirect = 1'b1;
        redirectPc = 32'($urandom_range(0, 4095));
        sb_restart(redirectPc);
      end else if (r == 3) begin
        redirect = 1'b0; reset = 1'b1;
        sb_restart(RPC);
      end else begin
        redirect = 1'b0; reset = 1'b0;
      end
      tick();
    end
    redirect = 1'b0; reset = 1'b0; instrReady = 1'b1;
    repeat (20) tick();
    chk("progress", 32'(consumed > 500), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
